// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified instruction/data memory between the
// pipeline fetch port (IF) and the load/store port (data). One transaction is
// in flight at a time. A three-state FSM sequences each transaction:
//   IDLE -> arbitrate and launch the access (or reject a misaligned one)
//   BUSY -> wait for mem_ack, giving up after TIMEOUT cycles
//   RESP -> the granted port sees its one-cycle ready (and err) pulse
// When both ports request, the port that did not win the previous grant
// is granted.
//
// Parameters:
//   TIMEOUT  cycles spent in BUSY without mem_ack before the access aborts (>=2)
//   AW       address width
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   if_req/if_addr       fetch request (level) and byte address
//   if_rdata/if_ready    fetched word, one-cycle completion pulse
//   if_err               abort indication, coincident with if_ready
//   d_req/d_we/d_addr    data request (level), store enable, byte address
//   d_wdata              store data
//   d_rdata/d_ready      load data, one-cycle completion pulse
//   d_err                abort indication, coincident with d_ready
//   mem_req/mem_we       memory request (held until ack) and write enable
//   mem_addr/mem_wdata   latched address and store data
//   mem_rdata/mem_ack    memory read data, valid with the single-cycle ack
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ready,
  output logic          if_err,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ready,
  output logic          d_err,

  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  // The counter only ever needs to reach TIMEOUT-1.
  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_reg;
  logic          grant_reg;   // 0 = IF, 1 = data
  logic          last_reg;    // port granted most recently, same encoding
  logic [CW-1:0] cnt_reg;

  // Arbitration decision, only acted upon in IDLE.
  logic          any_req;
  logic          pick_d;
  logic [AW-1:0] sel_addr;
  logic          sel_aligned;

  always_comb begin
    any_req     = if_req | d_req;
    // Data wins when it is alone, or when both request and IF won last time.
    pick_d      = d_req & (~if_req | ~last_reg);
    sel_addr    = pick_d ? d_addr : if_addr;
    sel_aligned = (sel_addr[1:0] == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      grant_reg <= 1'b0;
      last_reg  <= 1'b0;
      cnt_reg   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_ready  <= 1'b0;
      if_err    <= 1'b0;
      d_rdata   <= '0;
      d_ready   <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses; they are only raised on
      // the edge that moves the FSM into RESP, so they are high exactly
      // while the FSM sits in RESP.
      if_ready <= 1'b0;
      if_err   <= 1'b0;
      d_ready  <= 1'b0;
      d_err    <= 1'b0;

      unique case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_reg <= pick_d;
            last_reg  <= pick_d;
            if (sel_aligned) begin
              state_reg <= BUSY;
              mem_req   <= 1'b1;
              mem_addr  <= sel_addr;
              mem_we    <= pick_d & d_we;
              if (pick_d) begin
                mem_wdata <= d_wdata;
              end
              cnt_reg   <= '0;
            end else begin
              // Misaligned: never touch memory, report the error right away.
              state_reg <= RESP;
              if (pick_d) begin
                d_ready <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end else begin
                if_ready <= 1'b1;
                if_err   <= 1'b1;
                if_rdata <= '0;
              end
            end
          end
        end

        BUSY: begin
          // An ack takes priority over an expiring counter on the same edge.
          if (mem_ack) begin
            state_reg <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            if (grant_reg) begin
              d_ready <= 1'b1;
              // mem_we still holds d_we of this transaction; a store keeps
              // the previous load data visible.
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end else begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            if (grant_reg) begin
              d_ready <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end else begin
              if_ready <= 1'b1;
              if_err   <= 1'b1;
              if_rdata <= '0;
            end
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        RESP: begin
          // Requests are deliberately not sampled here, so a port still
          // holding req during its ready cycle waits for the next IDLE.
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
